exc_entry_ctrl: RTL and testbench
=================================

EXC_ENTRY_CTRL -- requirements
Module: exc_entry_ctrl

Interface
REQ-001 The block SHALL have parameter SIZE, default 32, meaning PC/data width.
REQ-002 The block SHALL have parameter ADDR, default 4, meaning register-address width.
REQ-003 The block SHALL have these ports, one per line:
- Clk  input  1  clock; all state changes on the rising edge
- Clr_n  input  1  reset, synchronous, active-low
- Irq  input  1  IRQ request, level
- Fiq  input  1  FIQ request, level
- Und  input  1  undefined-instruction request, level
- Swi  input  1  supervisor-call request, level
- Abt_D  input  1  data-abort request, level
- Exc_Ret  input  1  exception-return request, pulse
- PC_Cur  input  SIZE  PC of the current instruction
- Ret_PC  input  SIZE  return target supplied by datapath
- M  output  5  current processor mode, driven to the register file
- I_Mask  output  1  CPSR I bit
- F_Mask  output  1  CPSR F bit
- Write_Reg  output  1  register-file write strobe
- W_Addr  output  ADDR  register-file write address
- W_Data  output  SIZE  register-file write data
- Write_PC  output  1  PC write strobe
- PC_New  output  SIZE  new PC value
- Busy  output  1  high when not IDLE
- Exc_Ack  output  1  one-cycle pulse on entry completion

Function
REQ-004 Mode encodings SHALL be: usr 10000, fiq 10001, irq 10010, svc 10011, abt 10111, und 11011, sys 11111.
REQ-005 The FSM SHALL have states IDLE, SW_MODE, WR_LR, WR_PC, RET.
REQ-006 In IDLE, requests SHALL be sampled every cycle; priority Abt_D > Fiq > Irq > Und > Swi; Irq is ignored while I_Mask=1 and Fiq while F_Mask=1.
REQ-007 Target mode/vector: Abt_D -> abt/0x10, Fiq -> fiq/0x1C, Irq -> irq/0x18, Und -> und/0x04, Swi -> svc/0x08.
REQ-008 IDLE with an accepted request -> SW_MODE: {M,I,F} is saved into the target mode's SPSR; M becomes the target; I_Mask set to 1; F_Mask set to 1 for fiq entry only; the return address is latched.
REQ-009 The return address SHALL be PC_Cur+8 for Abt_D and PC_Cur+4 otherwise, truncated to SIZE bits (wrap modulo 2^SIZE).
REQ-010 SW_MODE -> WR_LR unconditionally; no strobes are asserted in SW_MODE, so the register file sees the new M before the LR write.
REQ-011 WR_LR: Write_Reg=1, W_Addr=14, W_Data=latched return address, for exactly one cycle; -> WR_PC.
REQ-012 WR_PC: Write_PC=1, PC_New=vector (zero-extended), Exc_Ack=1, for exactly one cycle; -> IDLE.
REQ-013 IDLE with Exc_Ret=1, no accepted request, and M not usr/sys -> RET; with M usr/sys, Exc_Ret SHALL be ignored.
REQ-014 RET: Write_PC=1, PC_New=Ret_PC for one cycle; {M,I,F} restored from the current mode's SPSR at the same edge; -> IDLE.
REQ-015 If an accepted request and Exc_Ret coincide, the exception SHALL win and Exc_Ret is dropped.
REQ-016 Requests and Exc_Ret arriving outside IDLE SHALL be ignored; level requests still asserted are re-evaluated on return to IDLE.
REQ-017 Nested entry (e.g. Fiq while in irq mode) SHALL be permitted; the SPSR of the new mode is overwritten.
REQ-018 Write_Reg, Write_PC and Exc_Ack SHALL never be high in the same cycle; W_Addr/W_Data/PC_New SHALL be 0 when their strobe is low.
REQ-019 Busy SHALL be 1 in every state except IDLE.

Reset
REQ-020 Clr_n=0 at a rising edge SHALL force IDLE, M=10011 (svc), I_Mask=1, F_Mask=1, all SPSRs=0, and all other outputs 0, from any state.
REQ-021 Reset mid-sequence SHALL suppress every pending LR/PC write after that edge.

Configuration
REQ-022 Macro EXC_FIQ_EN: when defined, FIQ behaves as above; when undefined, Fiq is ignored, the fiq SPSR is not implemented, and F_Mask is constant 1.

Verification
REQ-023 Reset, then Irq=0 -> M=10011, I_Mask=1, F_Mask=1, Busy=0, all strobes 0.
REQ-024 From usr (I=F=0), PC_Cur=0x100, Irq=1 -> cycle+1 M=10010; cycle+2 Write_Reg, W_Addr=14, W_Data=0x104; cycle+3 Write_PC, PC_New=0x18, Exc_Ack.
REQ-025 From usr, Abt_D=Fiq=Irq=1, PC_Cur=0xFFFFFFFC -> abt entry, W_Data=0x00000004, PC_New=0x10.
REQ-026 In irq mode (I=1,F=0), Fiq=1 -> fiq entry, fiq SPSR={10010,1,0}; then Exc_Ret, Ret_PC=0x200 -> Write_PC, PC_New=0x200, M=10010, I=1, F=0.
REQ-027 Clr_n=0 during WR_LR -> no Write_PC follows, M=10011 next cycle; Exc_Ret in usr -> no strobe, Busy stays 0.

Source files
------------

// File: rtl/exc_entry_ctrl.sv
// exc_entry_ctrl: exception entry/return sequencer.
// Accepts abort/FIQ/IRQ/undefined/SWI requests in IDLE, switches processor
// mode, banks {M,I,F} into the target mode's SPSR, writes the return
// address to LR (r14), then loads the exception vector into the PC.
// Exc_Ret restores {M,I,F} from the current mode's SPSR and loads Ret_PC.
//
// Build option: define EXC_FIQ_EN to implement the FIQ path. When it is
// undefined, Fiq is ignored, no fiq SPSR exists and F_Mask is fixed at 1.

module exc_entry_ctrl #(
    parameter int SIZE = 32,
    parameter int ADDR = 4
) (
    input  logic            Clk,
    input  logic            Clr_n,
    input  logic            Irq,
    input  logic            Fiq,
    input  logic            Und,
    input  logic            Swi,
    input  logic            Abt_D,
    input  logic            Exc_Ret,
    input  logic [SIZE-1:0] PC_Cur,
    input  logic [SIZE-1:0] Ret_PC,
    output logic [4:0]      M,
    output logic            I_Mask,
    output logic            F_Mask,
    output logic            Write_Reg,
    output logic [ADDR-1:0] W_Addr,
    output logic [SIZE-1:0] W_Data,
    output logic            Write_PC,
    output logic [SIZE-1:0] PC_New,
    output logic            Busy,
    output logic            Exc_Ack
);

    localparam logic [4:0] MODE_USR = 5'b10000;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_ABT = 5'b10111;
    localparam logic [4:0] MODE_UND = 5'b11011;
    localparam logic [4:0] MODE_SYS = 5'b11111;
`ifdef EXC_FIQ_EN
    localparam logic [4:0] MODE_FIQ = 5'b10001;
`endif

    typedef enum logic [2:0] {
        IDLE,
        SW_MODE,
        WR_LR,
        WR_PC,
        RET
    } state_t;

    state_t          state;
    logic [SIZE-1:0] ret_q;
    logic [SIZE-1:0] vec_q;

    // Banked SPSRs, each holding {M[4:0], I, F}
    logic [6:0]      spsr_svc;
    logic [6:0]      spsr_abt;
    logic [6:0]      spsr_und;
    logic [6:0]      spsr_irq;
`ifdef EXC_FIQ_EN
    logic [6:0]      spsr_fiq;
    logic            f_q;
`endif

    // Request decode results
    logic            acc;
    logic [4:0]      tgt_mode;
    logic [SIZE-1:0] tgt_vec;
    logic [SIZE-1:0] ret_addr;
    logic            fiq_req;
    logic            ret_ok;
    logic [6:0]      spsr_rd;

`ifdef EXC_FIQ_EN
    assign F_Mask  = f_q;
    assign fiq_req = Fiq & ~f_q;
`else
    logic unused_fiq;
    assign F_Mask     = 1'b1;
    assign fiq_req    = 1'b0;
    assign unused_fiq = Fiq ^ spsr_rd[0];
`endif

    // Prioritised request selection: Abt_D > Fiq > Irq > Und > Swi
    always_comb begin
        acc      = 1'b1;
        tgt_mode = MODE_SVC;
        tgt_vec  = '0;
        ret_addr = PC_Cur + SIZE'(4);
        if (Abt_D) begin
            tgt_mode = MODE_ABT;
            tgt_vec  = SIZE'(8'h10);
            ret_addr = PC_Cur + SIZE'(8);
        end else if (fiq_req) begin
`ifdef EXC_FIQ_EN
            tgt_mode = MODE_FIQ;
            tgt_vec  = SIZE'(8'h1C);
`endif
        end else if (Irq && !I_Mask) begin
            tgt_mode = MODE_IRQ;
            tgt_vec  = SIZE'(8'h18);
        end else if (Und) begin
            tgt_mode = MODE_UND;
            tgt_vec  = SIZE'(8'h04);
        end else if (Swi) begin
            tgt_mode = MODE_SVC;
            tgt_vec  = SIZE'(8'h08);
        end else begin
            acc = 1'b0;
        end
    end

    // SPSR of the current mode; modes without a bank read as zero
    always_comb begin
        spsr_rd = '0;
        case (M)
            MODE_SVC: spsr_rd = spsr_svc;
            MODE_ABT: spsr_rd = spsr_abt;
            MODE_UND: spsr_rd = spsr_und;
            MODE_IRQ: spsr_rd = spsr_irq;
`ifdef EXC_FIQ_EN
            MODE_FIQ: spsr_rd = spsr_fiq;
`endif
            default:  spsr_rd = '0;
        endcase
    end

    assign ret_ok = Exc_Ret && (M != MODE_USR) && (M != MODE_SYS);

    // Sequencer FSM with registered strobes, mode and mask bits
    always_ff @(posedge Clk) begin
        if (!Clr_n) begin
            state     <= IDLE;
            M         <= MODE_SVC;
            I_Mask    <= 1'b1;
`ifdef EXC_FIQ_EN
            f_q       <= 1'b1;
            spsr_fiq  <= '0;
`endif
            spsr_svc  <= '0;
            spsr_abt  <= '0;
            spsr_und  <= '0;
            spsr_irq  <= '0;
            ret_q     <= '0;
            vec_q     <= '0;
            Busy      <= 1'b0;
            Write_Reg <= 1'b0;
            W_Addr    <= '0;
            W_Data    <= '0;
            Write_PC  <= 1'b0;
            PC_New    <= '0;
            Exc_Ack   <= 1'b0;
        end else begin
            // Strobes and their data default low so each lasts one cycle
            Write_Reg <= 1'b0;
            W_Addr    <= '0;
            W_Data    <= '0;
            Write_PC  <= 1'b0;
            PC_New    <= '0;
            Exc_Ack   <= 1'b0;
            case (state)
                IDLE: begin
                    if (acc) begin
                        case (tgt_mode)
                            MODE_ABT: spsr_abt <= {M, I_Mask, F_Mask};
                            MODE_IRQ: spsr_irq <= {M, I_Mask, F_Mask};
                            MODE_UND: spsr_und <= {M, I_Mask, F_Mask};
`ifdef EXC_FIQ_EN
                            MODE_FIQ: spsr_fiq <= {M, I_Mask, F_Mask};
`endif
                            default:  spsr_svc <= {M, I_Mask, F_Mask};
                        endcase
                        M      <= tgt_mode;
                        I_Mask <= 1'b1;
`ifdef EXC_FIQ_EN
                        if (tgt_mode == MODE_FIQ) begin
                            f_q <= 1'b1;
                        end
`endif
                        ret_q  <= ret_addr;
                        vec_q  <= tgt_vec;
                        Busy   <= 1'b1;
                        state  <= SW_MODE;
                    end else if (ret_ok) begin
                        // Restore lands on the same edge the PC strobe rises
                        M        <= spsr_rd[6:2];
                        I_Mask   <= spsr_rd[1];
`ifdef EXC_FIQ_EN
                        f_q      <= spsr_rd[0];
`endif
                        Write_PC <= 1'b1;
                        PC_New   <= Ret_PC;
                        Busy     <= 1'b1;
                        state    <= RET;
                    end
                end
                SW_MODE: begin
                    Write_Reg <= 1'b1;
                    W_Addr    <= ADDR'(14);
                    W_Data    <= ret_q;
                    state     <= WR_LR;
                end
                WR_LR: begin
                    Write_PC <= 1'b1;
                    PC_New   <= vec_q;
                    Exc_Ack  <= 1'b1;
                    state    <= WR_PC;
                end
                default: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exc_entry_ctrl.sv
// tb_exc_entry_ctrl: directed and random stimulus for exc_entry_ctrl,
// checked every cycle against a transaction-level reference model.
// Build option EXC_FIQ_EN must match the RTL build.

module tb_exc_entry_ctrl;

    localparam int SIZE = 32;
    localparam int ADDR = 4;

`ifdef EXC_FIQ_EN
    localparam bit FIQ_EN = 1'b1;
`else
    localparam bit FIQ_EN = 1'b0;
`endif

    localparam logic [4:0] USR = 5'b10000;
    localparam logic [4:0] FIQ = 5'b10001;
    localparam logic [4:0] IRQ = 5'b10010;
    localparam logic [4:0] SVC = 5'b10011;
    localparam logic [4:0] ABT = 5'b10111;
    localparam logic [4:0] UND = 5'b11011;
    localparam logic [4:0] SYS = 5'b11111;

    logic            Clk = 1'b0;
    logic            Clr_n, Irq, Fiq, Und, Swi, Abt_D, Exc_Ret;
    logic [SIZE-1:0] PC_Cur, Ret_PC;
    logic [4:0]      M;
    logic            I_Mask, F_Mask, Write_Reg, Write_PC, Busy, Exc_Ack;
    logic [ADDR-1:0] W_Addr;
    logic [SIZE-1:0] W_Data, PC_New;

    exc_entry_ctrl #(.SIZE(SIZE), .ADDR(ADDR)) dut (
        .Clk(Clk), .Clr_n(Clr_n), .Irq(Irq), .Fiq(Fiq), .Und(Und), .Swi(Swi),
        .Abt_D(Abt_D), .Exc_Ret(Exc_Ret), .PC_Cur(PC_Cur), .Ret_PC(Ret_PC),
        .M(M), .I_Mask(I_Mask), .F_Mask(F_Mask), .Write_Reg(Write_Reg),
        .W_Addr(W_Addr), .W_Data(W_Data), .Write_PC(Write_PC), .PC_New(PC_New),
        .Busy(Busy), .Exc_Ack(Exc_Ack)
    );

    always #5 Clk = ~Clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: architectural state plus a queue of the output
    // pictures the remaining cycles of a running sequence must show.
    typedef struct {
        bit          busy;
        bit          wr;
        bit          wpc;
        bit          ack;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [31:0] pn;
    } obs_t;

    logic [4:0] md = SVC;
    logic       mi = 1'b1;
    logic       mf = 1'b1;
    logic [6:0] spsr [logic [4:0]];
    obs_t       q [$];
    obs_t       cur = '{default: 0};

    task automatic model_edge();
        obs_t        idle_o = '{default: 0};
        obs_t        o;
        logic [4:0]  tm;
        logic [31:0] vec, off;
        logic [6:0]  v;
        bit          take;
        if (!Clr_n) begin
            q.delete();
            spsr.delete();
            md = SVC; mi = 1'b1; mf = 1'b1;
            cur = idle_o;
            return;
        end
        if (cur.busy) begin
            cur = (q.size() > 0) ? q.pop_front() : idle_o;
            return;
        end
        take = 1'b1; off = 4; tm = SVC; vec = 0;
        if (Abt_D)                  begin tm = ABT; vec = 32'h10; off = 8; end
        else if (FIQ_EN && Fiq && !mf) begin tm = FIQ; vec = 32'h1C; end
        else if (Irq && !mi)        begin tm = IRQ; vec = 32'h18; end
        else if (Und)               begin tm = UND; vec = 32'h04; end
        else if (Swi)               begin tm = SVC; vec = 32'h08; end
        else take = 1'b0;
        if (take) begin
            spsr[tm] = {md, mi, mf};
            md = tm;
            mi = 1'b1;
            if (tm == FIQ) mf = 1'b1;
            o = idle_o; o.busy = 1;
            cur = o;
            o.wr = 1; o.wa = 4'd14; o.wd = PC_Cur + off;
            q.push_back(o);
            o = idle_o; o.busy = 1; o.wpc = 1; o.pn = vec; o.ack = 1;
            q.push_back(o);
        end else if (Exc_Ret && md != USR && md != SYS) begin
            v  = spsr.exists(md) ? spsr[md] : 7'd0;
            md = v[6:2];
            mi = v[1];
            mf = FIQ_EN ? v[0] : 1'b1;
            o = idle_o; o.busy = 1; o.wpc = 1; o.pn = Ret_PC;
            cur = o;
        end else begin
            cur = idle_o;
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        model_edge();
        #1;
        chk("M",         M,         md);
        chk("I_Mask",    I_Mask,    mi);
        chk("F_Mask",    F_Mask,    mf);
        chk("Busy",      Busy,      cur.busy);
        chk("Write_Reg", Write_Reg, cur.wr);
        chk("W_Addr",    W_Addr,    cur.wa);
        chk("W_Data",    W_Data,    cur.wd);
        chk("Write_PC",  Write_PC,  cur.wpc);
        chk("PC_New",    PC_New,    cur.pn);
        chk("Exc_Ack",   Exc_Ack,   cur.ack);
    endtask

    task automatic idle_in();
        Clr_n = 1; Irq = 0; Fiq = 0; Und = 0; Swi = 0; Abt_D = 0; Exc_Ret = 0;
    endtask

    initial begin
        idle_in();
        PC_Cur = '0; Ret_PC = '0;

        // Reset state
        Clr_n = 0; tick(); tick();
        chk("rst_M", M, 5'b10011);
        chk("rst_I", I_Mask, 1'b1);
        chk("rst_F", F_Mask, 1'b1);
        chk("rst_strobes", {Busy, Write_Reg, Write_PC, Exc_Ack}, 4'b0000);
        idle_in(); tick();
        chk("idle_busy", Busy, 1'b0);

        // Return through the cleared svc SPSR: unmasked, unbanked mode
        Exc_Ret = 1; Ret_PC = 32'h40; tick();
        chk("ret0_pc", PC_New, 32'h40);
        chk("ret0_M", M, 5'b00000);
        idle_in(); tick();

        // IRQ entry from an unmasked mode
        Irq = 1; PC_Cur = 32'h100; tick();
        chk("irq_M", M, IRQ);
        Irq = 0; tick();
        chk("irq_lr", {Write_Reg, W_Addr, W_Data}, {1'b1, 4'd14, 32'h104});
        tick();
        chk("irq_pc", {Write_PC, Exc_Ack, PC_New}, {2'b11, 32'h18});
        tick();
        Exc_Ret = 1; Ret_PC = 32'h300; tick();
        idle_in(); tick();

        // Abort beats FIQ and IRQ; return address wraps
        Abt_D = 1; Fiq = 1; Irq = 1; PC_Cur = 32'hFFFF_FFFC; tick();
        chk("abt_M", M, ABT);
        idle_in(); tick();
        chk("abt_lr", W_Data, 32'h0000_0004);
        tick();
        chk("abt_pc", PC_New, 32'h10);
        tick();
        Exc_Ret = 1; Ret_PC = 32'h80; tick();
        idle_in(); tick();

`ifdef EXC_FIQ_EN
        // Nested FIQ inside irq mode, then return to irq
        Irq = 1; PC_Cur = 32'h500; tick();
        idle_in(); tick(); tick(); tick();
        chk("nest_irq", {M, I_Mask, F_Mask}, {IRQ, 2'b10});
        Fiq = 1; tick();
        chk("nest_fiq", M, FIQ);
        idle_in(); tick(); tick(); tick();
        Exc_Ret = 1; Ret_PC = 32'h200; tick();
        chk("nest_ret_pc", {Write_PC, PC_New}, {1'b1, 32'h200});
        chk("nest_ret_st", {M, I_Mask, F_Mask}, {IRQ, 2'b10});
        idle_in(); tick();
`endif

        // Reset during WR_LR suppresses the PC write
        Swi = 1; tick();
        Swi = 0; tick();
        chk("mid_wr", Write_Reg, 1'b1);
        Clr_n = 0; tick();
        chk("mid_M", M, SVC);
        chk("mid_wpc", Write_PC, 1'b0);
        idle_in(); tick();
        chk("mid_wpc2", {Write_PC, Busy}, 2'b00);

        // Exc_Ret while busy is dropped
        Und = 1; PC_Cur = 32'h700; tick();
        Und = 0; Exc_Ret = 1; tick(); tick(); tick();
        idle_in(); tick();

        // Random stimulus
        for (int n = 0; n < 4000; n++) begin
            Clr_n   = ($urandom_range(0, 79) != 0);
            Abt_D   = ($urandom_range(0, 22) == 0);
            Fiq     = ($urandom_range(0, 10) == 0);
            Irq     = ($urandom_range(0, 6) == 0);
            Und     = ($urandom_range(0, 18) == 0);
            Swi     = ($urandom_range(0, 12) == 0);
            Exc_Ret = ($urandom_range(0, 3) == 0);
            PC_Cur  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : $urandom;
            Ret_PC  = $urandom;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
